// File: rtl/text_line_renderer.sv
// text_line_renderer: fetches one text line from RAM, drives the glyph decoder and
// streams the glyph rows out as a row-major serial pixel stream over valid/ready.
module text_line_renderer #(
    parameter int COLS = 80,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          cursor_en,
    input  logic [6:0]    cursor_col,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    input  logic [6:0]    ram_data,
    output logic [6:0]    dec_code,
    input  logic [127:0]  dec_glyph,
    output logic          pix_out,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_eol,
    output logic          pix_last,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, SHIFT, DONE} state_t;
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    state_t        state;
    logic [AW-1:0] base_q;
    logic          cen_q;
    logic [6:0]    ccol_q;
    logic [6:0]    col;
    logic [3:0]    grow;
    logic [2:0]    bitc;
    logic [7:0]    sh;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            base_q   <= '0;
            cen_q    <= 1'b0;
            ccol_q   <= '0;
            col      <= '0;
            grow     <= '0;
            bitc     <= '0;
            sh       <= '0;
            dec_code <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    cen_q  <= cursor_en;
                    ccol_q <= cursor_col;
                    col    <= '0;
                    grow   <= '0;
                    state  <= READ;
                end
                READ: state <= WAIT;
                WAIT: begin
                    dec_code <= ram_data;
                    state    <= LOAD;
                end
                // Row r of the glyph sits at bits [127-8r -: 8], i.e. index {~r,3'b111}
                LOAD: begin
                    sh    <= dec_glyph[{~grow, 3'b111} -: 8] ^ {8{cen_q && ccol_q == col}};
                    bitc  <= 3'd7;
                    state <= SHIFT;
                end
                SHIFT: if (pix_ready) begin
                    sh   <= sh << 1;
                    bitc <= bitc - 3'd1;
                    if (bitc == 3'd0) begin
                        if (col != LAST_COL) begin
                            col   <= col + 7'd1;
                            state <= READ;
                        end else if (grow != 4'd15) begin
                            col   <= '0;
                            grow  <= grow + 4'd1;
                            state <= READ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign ram_rd    = state == READ;
    assign ram_addr  = base_q + AW'(col);
    assign pix_valid = state == SHIFT;
    assign pix_out   = pix_valid && sh[7];
    assign pix_eol   = pix_valid && col == LAST_COL && bitc == 3'd0;
    assign pix_last  = pix_eol && grow == 4'd15;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
endmodule

// File: tb/tb_text_line_renderer.sv
// tb_text_line_renderer: randomized line renders checked beat by beat against a
// row-major reference built from the font table and RAM contents.
module tb_text_line_renderer;
    localparam int COLS = 2;
    localparam int AW   = 12;
    localparam int NB   = COLS * 128;

    logic          clk = 0;
    logic          resetn = 0;
    logic          start = 0;
    logic [AW-1:0] base_addr = '0;
    logic          cursor_en = 0;
    logic [6:0]    cursor_col = '0;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [6:0]    ram_data = '0;
    logic [6:0]    dec_code;
    logic [127:0]  dec_glyph;
    logic          pix_out, pix_valid, pix_eol, pix_last, busy, done;
    logic          pix_ready = 0;

    logic [6:0] mem [0:(1<<AW)-1];
    int pass_cnt = 0;
    int total = 0;
    logic [2:0] exp_beat [0:NB-1];

    text_line_renderer #(.COLS(COLS), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .ram_rd(ram_rd),
        .ram_addr(ram_addr), .ram_data(ram_data), .dec_code(dec_code),
        .dec_glyph(dec_glyph), .pix_out(pix_out), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_eol(pix_eol), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

    // Font row for a code: controls and DEL are blank, row 0 is always blank.
    function automatic logic [7:0] font_row(input logic [6:0] code, input int r);
        if (code < 7'd32 || code == 7'd127 || r == 0) return 8'h00;
        if (code == 7'd65 && r == 1) return 8'h18;
        if (code == 7'd49 && r == 1) return 8'h10;
        return 8'((int'(code) * 37 + r * 113) ^ (int'(code) >> 1));
    endfunction

    always_comb
        for (int r = 0; r < 16; r++) dec_glyph[127 - 8*r -: 8] = font_row(dec_code, r);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic build_model(input logic [AW-1:0] base, input logic cen, input logic [6:0] ccol);
        int k = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] row = font_row(mem[AW'(base + AW'(c))], r);
                if (cen && int'(ccol) == c) row = ~row;
                for (int b = 7; b >= 0; b--) begin
                    exp_beat[k] = {row[b], c == COLS-1 && b == 0, c == COLS-1 && b == 0 && r == 15};
                    k++;
                end
            end
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. abort_at<0 disables abort.
    task automatic run_line(input logic [AW-1:0] base, input logic cen, input logic [6:0] ccol,
                            input int mode, input int abort_at);
        int beat = 0, cyc = 0, rd_cnt = 0;
        logic stalled = 0;
        logic [2:0] held = '0;
        logic [3:0] pat = 4'b1001;
        build_model(base, cen, ccol);
        @(negedge clk);
        base_addr = base; cursor_en = cen; cursor_col = ccol; start = 1;
        @(negedge clk);
        start = 0;
        base_addr = AW'($urandom); cursor_en = ~cen; cursor_col = 7'($urandom);
        check("busy_after_start", busy, 1);
        check("first_ram_rd", ram_rd, 1);
        while (beat < NB && cyc < 8000) begin
            if (beat == abort_at) begin
                resetn = 0;
                #1;
                check("abort_outputs", {pix_valid, busy, done, ram_rd}, 0);
                @(negedge clk);
                resetn = 1;
                return;
            end
            start = (cyc == 37);
            pix_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom);
            if (ram_rd) begin
                check("ram_addr", ram_addr, AW'(base + AW'(rd_cnt % COLS)));
                rd_cnt++;
            end
            if (stalled) check("stall_hold", {pix_valid, pix_out, pix_eol, pix_last}, {1'b1, held});
            if (pix_valid && pix_ready) begin
                check($sformatf("beat%0d", beat), {pix_out, pix_eol, pix_last}, exp_beat[beat]);
                beat++;
            end
            stalled = pix_valid && !pix_ready;
            held = {pix_out, pix_eol, pix_last};
            @(negedge clk);
            cyc++;
        end
        start = 0;
        check("beat_count", beat, NB);
        check("done_pulse", {done, busy}, 2'b10);
        start = 1;
        @(negedge clk);
        start = 0;
        check("done_cleared", {done, busy}, 2'b00);
        check("ram_rd_total", rd_cnt, COLS * 16);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 7'($urandom_range(32, 126));
        #12;
        check("reset_state", {ram_addr, dec_code, pix_valid, pix_out, busy, done, ram_rd}, 0);
        resetn = 1;
        mem[12'h100] = 7'd65; mem[12'h101] = 7'd49;
        run_line(12'h100, 0, 7'd0, 0, -1);
        run_line(12'h100, 0, 7'd0, 1, -1);
        run_line(12'h100, 1, 7'd1, 0, -1);
        run_line(12'h100, 1, 7'd5, 2, -1);
        mem[12'hFFF] = 7'($urandom_range(32, 126)); mem[12'h000] = 7'($urandom_range(32, 126));
        run_line(12'hFFF, 1, 7'd0, 2, -1);
        run_line(12'h200, 0, 7'd0, 0, 100);
        mem[12'h200] = 7'd10;
        run_line(12'h200, 0, 7'd0, 2, -1);
        for (int n = 0; n < 3; n++)
            run_line(AW'($urandom), 1'($urandom), 7'($urandom_range(0, 3)), 2, -1);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
